// File: rtl/sum_uart_pkg.sv
`timescale 1ns/1ps
// sum_uart_pkg
// Shared constants for the sum accumulator / UART transmitter slice.
//   ACC_W      : width of the running accumulator and transmitted total
//   BIT_IDX_W  : width of the data-bit index inside one 8-bit UART frame
//   state_t    : serialiser state encoding (ACCUM doubles as "line idle")
package sum_uart_pkg;

  localparam int ACC_W     = 16;
  localparam int BIT_IDX_W = 3;

  typedef logic [1:0] state_t;

  localparam state_t ACCUM = 2'd0;
  localparam state_t START = 2'd1;
  localparam state_t DATA  = 2'd2;
  localparam state_t STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_byte.sv
`timescale 1ns/1ps
// uart_tx_byte
// Serialises one byte as an 8N1 UART frame (start bit, 8 data bits LSB
// first, one stop bit), each bit held CLKS_PER_BIT clocks.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (line returns idle high)
//   start_i   : begin a frame with data_i; honoured when idle or in the
//               final cycle of a stop bit (so frames can be chained gap-free)
//   data_i    : byte to send, captured when start_i is honoured
//   tx_o      : registered UART line, idle high
//   done_o    : high during the last cycle of the stop bit
module uart_tx_byte
  import sum_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       done_o
);

  localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);

  state_t               state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 bit_end;

  assign bit_end = (timer_q == TMR_LAST);

  // tx is computed one cycle ahead so the line changes exactly on the edge
  // where a bit period ends; the shift register always holds the current
  // bit in position 0, so the next bit to drive is shift_q[1].
  always_comb begin
    state_d   = state_q;
    timer_d   = bit_end ? '0 : timer_q + TMR_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    case (state_q)
      ACCUM: begin
        timer_d = '0;
        if (start_i) begin
          state_d = START;
          shift_d = data_i;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == '1) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (start_i) begin
            state_d = START;
            shift_d = data_i;
            tx_d    = 1'b0;
          end else begin
            state_d = ACCUM;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ACCUM;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  assign tx_o   = tx_q;
  assign done_o = (state_q == STOP) && bit_end;

endmodule

// File: rtl/sum_uart_tx.sv
`timescale 1ns/1ps
// sum_uart_tx
// Accumulates ACC_COUNT unsigned 8-bit sum samples into a 16-bit total,
// then sends the total as two 8N1 UART frames (low byte first) and clears
// itself for the next batch.
// Configuration macro: SUM_UART_TX_SAT_EN
//   defined   -> accumulator saturates at 0xFFFF
//   undefined -> accumulator wraps modulo 2^16
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    : sample present
//   in_data     : unsigned 8-bit sample
//   in_ready    : sample accepted this cycle when in_valid is also high
//   tx          : UART line, idle high
//   busy        : transmission in progress
//   frame_done  : one-cycle pulse once the high byte's stop bit completes
//   acc_value   : running accumulator (debug)
module sum_uart_tx
  import sum_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int ACC_COUNT    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             tx,
  output logic             busy,
  output logic             frame_done,
  output logic [ACC_W-1:0] acc_value
);

  localparam int CNT_W = $clog2(ACC_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_COUNT - 1);

  logic             sending_q, sending_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             byte_idx_q, byte_idx_d;

  logic             accept;
  logic             last_sample;
  logic [ACC_W-1:0] acc_sum;
  logic             byte_start;
  logic [7:0]       byte_data;
  logic             byte_done;

  // in_ready_q is only ever high while accumulating, so it alone gates accepts.
  assign accept      = in_valid && in_ready_q;
  assign last_sample = accept && (cnt_q == CNT_LAST);

`ifdef SUM_UART_TX_SAT_EN
  // One extra bit catches the carry out; any carry pins the total at all-ones.
  logic [ACC_W:0] acc_wide;
  assign acc_wide = {1'b0, acc_q} + (ACC_W + 1)'(in_data);
  assign acc_sum  = acc_wide[ACC_W] ? '1 : acc_wide[ACC_W-1:0];
`else
  assign acc_sum = acc_q + ACC_W'(in_data);
`endif

  // The accumulator is frozen while sending, so it also serves as the
  // latched transmit total. The low byte is handed to the serialiser on the
  // accepting edge (from acc_sum, since acc_q is not updated yet); the high
  // byte is chained in on the low byte's final stop-bit cycle so there is
  // no idle gap between the two frames.
  always_comb begin
    sending_d    = sending_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    byte_idx_d   = byte_idx_q;
    frame_done_d = 1'b0;
    byte_start   = 1'b0;
    byte_data    = acc_sum[7:0];
    if (!sending_q) begin
      if (accept) begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (last_sample) begin
        sending_d  = 1'b1;
        byte_idx_d = 1'b0;
        byte_start = 1'b1;
        byte_data  = acc_sum[7:0];
      end
    end else if (byte_done) begin
      if (!byte_idx_q) begin
        byte_idx_d = 1'b1;
        byte_start = 1'b1;
        byte_data  = acc_q[15:8];
      end else begin
        sending_d    = 1'b0;
        frame_done_d = 1'b1;
        acc_d        = '0;
        cnt_d        = '0;
      end
    end
    in_ready_d = !sending_d;
    busy_d     = sending_d;
  end

  // Status flags are registered so they line up with the registered tx line;
  // in_ready stays low through reset and rises on the first free-running edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sending_q    <= 1'b0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      acc_q        <= '0;
      cnt_q        <= '0;
      byte_idx_q   <= 1'b0;
    end else begin
      sending_q    <= sending_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      byte_idx_q   <= byte_idx_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk    (clk),
    .rst    (rst),
    .start_i(byte_start),
    .data_i (byte_data),
    .tx_o   (tx),
    .done_o (byte_done)
  );

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign acc_value  = acc_q;

endmodule

// File: tb/tb_sum_uart_tx.sv
`timescale 1ns/1ps
// tb_sum_uart_tx
// Scoreboard bench for sum_uart_tx. Stimulus pushes expected totals and
// UART bytes into queues; independent monitors decode the tx line at bit
// centres and check the latched total and frame timing as they appear.
// A second instance with ACC_COUNT=300 exercises accumulator overflow.
module tb_sum_uart_tx;

  localparam int CPB   = 4;
  localparam int ACCN  = 4;
  localparam int CPB2  = 2;
  localparam int ACCN2 = 300;
`ifdef SUM_UART_TX_SAT_EN
  localparam logic [15:0] OVF_EXP = 16'hFFFF;
`else
  localparam logic [15:0] OVF_EXP = 16'h2AD4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, tx, busy, frame_done;
  logic [15:0] acc_value;

  logic        in_valid2 = 1'b0;
  logic [7:0]  in_data2 = 8'h00;
  logic        in_ready2, tx2, busy2, frame_done2;
  logic [15:0] acc_value2;

  int tests = 0;
  int fails = 0;
  logic [7:0]  expQ[$];
  logic [15:0] totQ[$];
  int expFrames = 0;
  int frameDoneCount = 0;
  int rstCount = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  sum_uart_tx #(.CLKS_PER_BIT(CPB), .ACC_COUNT(ACCN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx(tx), .busy(busy), .frame_done(frame_done),
    .acc_value(acc_value)
  );

  sum_uart_tx #(.CLKS_PER_BIT(CPB2), .ACC_COUNT(ACCN2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .tx(tx2), .busy(busy2), .frame_done(frame_done2),
    .acc_value(acc_value2)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushBatch(input logic [15:0] total);
    totQ.push_back(total);
    expQ.push_back(total[7:0]);
    expQ.push_back(total[15:8]);
    expFrames++;
  endtask

  // Called at a negedge; offers one sample, waits for acceptance, returns at
  // the negedge after the accepting edge and checks the running total.
  task automatic applyStimulus(input logic [7:0] d, input logic [15:0] expAcc);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("acc_after_sample", 32'(acc_value), 32'(expAcc));
  endtask

  task automatic waitFrameDone(input int budget);
    int n = 0;
    while (frame_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("frame_done_seen", 32'(frame_done), 32'd1);
  endtask

  always @(posedge clk) if (rst) rstCount++;

  // UART decoder: samples each bit at its centre; a frame overlapped by
  // reset is discarded without consuming an expected byte.
  initial begin : uartMon
    logic [7:0] b;
    logic       startOk, stopOk;
    int         r0;
    b = 8'h00;
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && rst === 1'b0) begin
        r0 = rstCount;
        repeat (CPB / 2) @(negedge clk);
        startOk = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        stopOk = (tx === 1'b1);
        if (rstCount == r0) begin
          if (expQ.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL uart_unexpected_byte: got 0x%0h, expected none", b);
          end else begin
            checkOutput("uart_byte", 32'(b), 32'(expQ.pop_front()));
          end
          checkOutput("uart_framing", 32'({startOk, stopOk}), 32'd3);
        end
      end
    end
  end

  // Frame monitor: latched total when busy rises, frame length and status
  // flags in the frame_done cycle.
  initial begin : frameMon
    logic prevBusy;
    int   fallCyc;
    prevBusy = 1'b0;
    fallCyc  = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1 && !prevBusy) begin
        fallCyc = cyc;
        checkOutput("tx_falls_with_busy", 32'(tx), 32'd0);
        if (totQ.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_batch: got total 0x%0h, expected none", acc_value);
        end else begin
          checkOutput("latched_total", 32'(acc_value), 32'(totQ.pop_front()));
        end
      end
      if (frame_done === 1'b1) begin
        frameDoneCount++;
        checkOutput("frame_len", 32'(cyc - fallCyc), 32'(20 * CPB));
        checkOutput("ready_at_frame_done", 32'(in_ready), 32'd1);
        checkOutput("busy_clear_at_frame_done", 32'(busy), 32'd0);
      end
      prevBusy = (busy === 1'b1);
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    int accepted, lowRun, n, fdc, acc2n;

    // Power-up reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tx", 32'(tx), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_acc", 32'(acc_value), 32'd0);
    checkOutput("rst_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_tx2", 32'(tx2), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", 32'(in_ready), 32'd1);
    checkOutput("ready2_after_rst", 32'(in_ready2), 32'd1);

    // Basic batch: 0x10+0x20+0x30+0x40 = 0x00A0
    pushBatch(16'h00A0);
    applyStimulus(8'h10, 16'h0010);
    applyStimulus(8'h20, 16'h0030);
    applyStimulus(8'h30, 16'h0060);
    applyStimulus(8'h40, 16'h00A0);
    checkOutput("basic_tx_low", 32'(tx), 32'd0);
    checkOutput("basic_busy", 32'(busy), 32'd1);
    checkOutput("basic_not_ready", 32'(in_ready), 32'd0);
    waitFrameDone(200);
    checkOutput("basic_acc_cleared", 32'(acc_value), 32'd0);

    // Back-to-back: sample offered in the frame_done cycle is taken
    pushBatch(16'h0022);
    applyStimulus(8'h07, 16'h0007);
    applyStimulus(8'h08, 16'h000F);
    applyStimulus(8'h09, 16'h0018);
    applyStimulus(8'h0A, 16'h0022);
    waitFrameDone(200);

    // Backpressure: in_valid held high with 0x01 for two batches
    pushBatch(16'h0004);
    pushBatch(16'h0004);
    accepted = 0;
    lowRun   = 0;
    in_valid = 1'b1;
    in_data  = 8'h01;
    for (int i = 0; i < 400; i++) begin
      if (in_ready === 1'b1) begin
        if (lowRun > 0) begin
          checkOutput("bp_ready_low_run", 32'(lowRun), 32'(20 * CPB));
          lowRun = 0;
        end
        accepted++;
        if (accepted == 2 * ACCN) break;
      end else begin
        lowRun++;
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp_accepts", 32'(accepted), 32'(2 * ACCN));
    waitFrameDone(200);

    // Reset during the high byte's data bits: 4 x 0x40 = 0x0100
    totQ.push_back(16'h0100);
    expQ.push_back(8'h00);
    applyStimulus(8'h40, 16'h0040);
    applyStimulus(8'h40, 16'h0080);
    applyStimulus(8'h40, 16'h00C0);
    applyStimulus(8'h40, 16'h0100);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_tx", 32'(tx), 32'd1);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_acc", 32'(acc_value), 32'd0);
    checkOutput("midrst_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fdc = frameDoneCount;
    repeat (60) @(negedge clk);
    checkOutput("midrst_no_frame_done", 32'(frameDoneCount), 32'(fdc));
    checkOutput("midrst_ready_again", 32'(in_ready), 32'd1);

    // Batch after reset: 4 x 0x05 = 0x0014
    pushBatch(16'h0014);
    applyStimulus(8'h05, 16'h0005);
    applyStimulus(8'h05, 16'h000A);
    applyStimulus(8'h05, 16'h000F);
    applyStimulus(8'h05, 16'h0014);
    waitFrameDone(200);

    // Overflow: 300 x 0xFF on the second instance
    in_valid2 = 1'b1;
    in_data2  = 8'hFF;
    acc2n = 0;
    n = 0;
    while (busy2 !== 1'b1 && n < 1000) begin
      if (in_ready2 === 1'b1) acc2n++;
      @(negedge clk);
      n++;
    end
    in_valid2 = 1'b0;
    checkOutput("ovf_accepts", 32'(acc2n), 32'(ACCN2));
    checkOutput("ovf_total", 32'(acc_value2), 32'(OVF_EXP));
    checkOutput("ovf_tx_low", 32'(tx2), 32'd0);
    n = 0;
    while (frame_done2 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ovf_frame_len", 32'(n), 32'(20 * CPB2));
    checkOutput("ovf_acc_cleared", 32'(acc_value2), 32'd0);

    // Drain and reconcile the scoreboard
    repeat (50) @(negedge clk);
    checkOutput("bytes_outstanding", 32'(expQ.size()), 32'd0);
    checkOutput("totals_outstanding", 32'(totQ.size()), 32'd0);
    checkOutput("frame_done_count", 32'(frameDoneCount), 32'(expFrames));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sum_uart_tx.md
# sum_uart_tx

Downstream consumer of the 8-bit operand-sum output stage. Accepts sum samples over a valid/ready handshake and accumulates ACC_COUNT of them into a 16-bit total. It then transmits the total on a single-wire UART line as two 8N1 frames, low byte first, and clears itself for the next batch. It drives one dedicated output pin (tx) plus status flags for the top level.

## Interface
- CLKS_PER_BIT, default 434: clock cycles per UART bit (115200 baud at 50 MHz); minimum 2.
- ACC_COUNT, default 4: samples accumulated per transmitted total; range 1..1024.
- clk  in  1  clock. One clock; reset is synchronous and active-high.
- rst  in  1  reset.
- in_valid  in  1  sum sample present.
- in_data  in  8  unsigned sum sample.
- in_ready  out  1  block accepts a sample this cycle.
- tx  out  1  UART line, idle high.
- busy  out  1  transmission in progress.
- frame_done  out  1  one-cycle pulse when the second stop bit completes.
- acc_value  out  16  running accumulator, for debug.

## Operation
- States: ACCUM, START, DATA, STOP. A byte index (0 = low byte, 1 = high byte) selects which half of the latched total is sent.
- ACCUM:
  - in_ready=1, tx=1, busy=0.
  - A sample is accepted on each edge where in_valid && in_ready; acc_value += in_data (zero-extended to 16 bits); sample count increments.
  - When the ACC_COUNT-th sample is accepted: the result including that sample is latched as the transmit total, byte index is set to 0, and the next state is START.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: 8 bits of the selected byte, LSB first, each held CLKS_PER_BIT cycles, then STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles.
  - If byte index is 0: byte index becomes 1, go to START.
  - Otherwise: pulse frame_done, clear acc_value and sample count, go to ACCUM.
- in_ready=0 and busy=1 in START, DATA and STOP. in_valid is ignored in those states; upstream holds its data.
- Arithmetic:
  - The accumulator is 16 bits; its overflow behaviour is set by the macro under Configuration.
  - The sample count is ceil(log2(ACC_COUNT+1)) bits wide and never wraps.
- Reset mid-operation:
  - Any state returns to ACCUM on the next edge.
  - tx=1, acc_value and count cleared; a partial frame is abandoned with no frame_done.

## Timing
- Reset values (registered, valid from the edge where rst=1): state ACCUM, tx=1, busy=0, frame_done=0, acc_value=0, in_ready=0 while rst=1 and 1 from the first cycle after rst deasserts.
- Sample latency: acc_value reflects an accepted sample the cycle after the accepting edge.
- Start of transmission: tx falls the cycle after the ACC_COUNT-th accept. busy and in_ready change in that same cycle.
- Frame length: 20 × CLKS_PER_BIT cycles from tx falling to the frame_done cycle.
- frame_done and in_ready=1 occur in the same cycle. A sample offered in that cycle is accepted into the new batch, so there is no dead cycle.
- in_valid asserted while in_ready=0 has no effect and does not stall state.

## Configuration
- SUM_UART_TX_SAT_EN defined: the accumulator saturates at 0xFFFF and further samples leave it at 0xFFFF.
- SUM_UART_TX_SAT_EN undefined: the accumulator wraps modulo 2^16.
- Both builds are otherwise cycle-identical.

## Structure
- Package sum_uart_pkg holds:
  - the state enum (ACCUM, START, DATA, STOP)
  - the ACC_W=16 constant
  - the bit-index width constant (3)
- Sub-module uart_tx_byte contains the bit timer, the shift register and the START/DATA/STOP sequencing for one byte.
  - Handshake: start/byte in, done pulse out.
  - The top level contains the accumulator, sample counter, byte index and ACCUM control.

## Test plan
- Reset: rst=1 for 3 cycles, mid-stream and at power-up -> tx=1, busy=0, acc_value=0, in_ready=0 during rst and 1 one cycle after.
- Basic batch (CLKS_PER_BIT=4, ACC_COUNT=4): send 0x10, 0x20, 0x30, 0x40 -> acc_value 0x00A0. Sampling at bit centres gives frame 0xA0 then frame 0x00, LSB first. frame_done fires 80 cycles after tx first falls.
- Backpressure: hold in_valid=1 with 0x01 continuously -> exactly 4 samples accepted per batch. in_ready stays 0 for 80 cycles, then resumes. Each total is 0x0004.
- Overflow (ACC_COUNT=300, all samples 0xFF) -> transmitted total 0xFFFF with SUM_UART_TX_SAT_EN, 0x2AD4 without.
- Reset mid-frame: assert rst during the DATA bits of the high byte -> tx=1 next cycle, no frame_done. The next batch of 4 × 0x05 transmits 0x14, 0x00.
- Back-to-back: offer a sample in the frame_done cycle -> it is accepted and acc_value equals that sample on the following cycle.
